// File: rtl/fmap_stream_tx_pkg.sv
// Shared types and defaults for the feature-map stream transmitter.
// Build option: FMAP_STREAM_TX_PINGPONG_EN selects a double-buffered feature map.
package fmap_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_NUM_CH = 4;
  localparam int DEF_IMG_W  = 15;
  localparam int DEF_IMG_H  = 15;

  typedef enum logic [2:0] {
    FSM_IDLE    = 3'd0,
    FSM_LOAD    = 3'd1,
    FSM_WAIT_LS = 3'd2,
    FSM_STREAM  = 3'd3,
    FSM_FLUSH   = 3'd4
  } fsm_e;

  typedef logic [DEF_NUM_CH-1:0][DEF_DATA_W-1:0] pix_t;

  function automatic int frame_pix(input int w, input int h);
    return w * h;
  endfunction

  localparam int FRAME_PIX = frame_pix(DEF_IMG_W, DEF_IMG_H);

endpackage

// File: rtl/fmap_stream_tx_if.sv
// Host write port, frame control and layer-input stream of fmap_stream_tx.
// master is the transmitter's view; slave is the host / conv-layer side.
interface fmap_stream_tx_if import fmap_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int ADDR_W = $clog2(FRAME_PIX)
);

  logic                           wr_en;
  logic [ADDR_W-1:0]              wr_addr;
  logic [NUM_CH-1:0][DATA_W-1:0]  wr_data;
  logic                           start;
  logic                           busy;
  logic                           done;
  logic                           load;
  logic                           load_success;
  logic                           out_valid;
  logic                           sof;
  logic [NUM_CH-1:0][DATA_W-1:0]  d_out;

  modport master (
    input  wr_en, wr_addr, wr_data, start, load_success,
    output busy, done, load, out_valid, sof, d_out
  );

  modport slave (
    output wr_en, wr_addr, wr_data, start, load_success,
    input  busy, done, load, out_valid, sof, d_out
  );

endinterface

// File: rtl/fmap_stream_tx_buf_ram.sv
// One-write/one-read synchronous feature-map buffer; a read colliding with a
// write at the same address returns the word held before the write.
module fmap_buf_ram import fmap_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int DEPTH  = FRAME_PIX,
  parameter int ADDR_W = $clog2(FRAME_PIX)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [ADDR_W-1:0]             wr_addr,
  input  logic [NUM_CH-1:0][DATA_W-1:0] wr_data,
  input  logic                          rd_en,
  input  logic [ADDR_W-1:0]             rd_addr,
  output logic [NUM_CH-1:0][DATA_W-1:0] rd_data
);

  logic [NUM_CH-1:0][DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en && (int'(wr_addr) < DEPTH)) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Only the output register is reset; the array keeps its contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/fmap_stream_tx.sv
// Feature-map transmitter: one-time weight-load handshake, then raster streaming.
// Build option: FMAP_STREAM_TX_PINGPONG_EN (host fills one bank while the other streams).
module fmap_stream_tx import fmap_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int IMG_W  = DEF_IMG_W,
  parameter int IMG_H  = DEF_IMG_H,
  parameter int GAP    = 0
) (
  input logic              clk,
  input logic              rst,
  fmap_stream_tx_if.master bus
);

  localparam int NPIX   = frame_pix(IMG_W, IMG_H);
  localparam int ADDR_W = $clog2(NPIX);
  localparam int GAP_W  = (GAP > 0) ? $clog2(GAP + 1) : 1;

  localparam logic [2:0] IDLE    = FSM_IDLE;
  localparam logic [2:0] LOAD    = FSM_LOAD;
  localparam logic [2:0] WAIT_LS = FSM_WAIT_LS;
  localparam logic [2:0] STREAM  = FSM_STREAM;
  localparam logic [2:0] FLUSH   = FSM_FLUSH;

  logic [2:0]                    state;
  logic                          wl_done;
  logic [ADDR_W-1:0]             pix_cnt;
  logic [GAP_W-1:0]              gap_cnt;
  logic                          rd_en;
  logic                          last_addr;
  logic                          start_acc;
  logic [NUM_CH-1:0][DATA_W-1:0] rd_data;

  assign start_acc = (state == IDLE) && bus.start;
  assign rd_en     = (state == STREAM) && (gap_cnt == '0);
  assign last_addr = (pix_cnt == ADDR_W'(NPIX - 1));
  assign bus.d_out = rd_data;

  // out_valid/sof trail the address issue by one cycle to line up with the RAM read.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      wl_done       <= 1'b0;
      pix_cnt       <= '0;
      gap_cnt       <= '0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.load      <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.sof       <= 1'b0;
    end else begin
      bus.done      <= 1'b0;
      bus.load      <= 1'b0;
      bus.out_valid <= rd_en;
      bus.sof       <= rd_en && (pix_cnt == '0);
      case (state)
        IDLE: begin
          if (start_acc) begin
            bus.busy <= 1'b1;
            pix_cnt  <= '0;
            gap_cnt  <= '0;
            if (wl_done) begin
              state <= STREAM;
            end else begin
              state    <= LOAD;
              bus.load <= 1'b1;
            end
          end
        end
        LOAD: state <= WAIT_LS;
        WAIT_LS: begin
          if (bus.load_success) begin
            wl_done <= 1'b1;
            state   <= STREAM;
          end
        end
        STREAM: begin
          if (rd_en) begin
            if (last_addr) begin
              state <= FLUSH;
            end else begin
              pix_cnt <= pix_cnt + 1'b1;
              gap_cnt <= GAP_W'(GAP);
            end
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        FLUSH: begin
          bus.done <= 1'b1;
          bus.busy <= 1'b0;
          pix_cnt  <= '0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FMAP_STREAM_TX_PINGPONG_EN
  logic                          wr_bank;
  logic                          rd_sel;
  logic [NUM_CH-1:0][DATA_W-1:0] rd_data0;
  logic [NUM_CH-1:0][DATA_W-1:0] rd_data1;

  // rd_sel follows the bank actually read so d_out holds across a bank swap.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bank <= 1'b0;
      rd_sel  <= 1'b0;
    end else begin
      if (start_acc) wr_bank <= ~wr_bank;
      if (rd_en)     rd_sel  <= ~wr_bank;
    end
  end

  fmap_buf_ram #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .DEPTH(NPIX), .ADDR_W(ADDR_W)) u_bank0 (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (bus.wr_en && !wr_bank),
    .wr_addr (bus.wr_addr),
    .wr_data (bus.wr_data),
    .rd_en   (rd_en && wr_bank),
    .rd_addr (pix_cnt),
    .rd_data (rd_data0)
  );

  fmap_buf_ram #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .DEPTH(NPIX), .ADDR_W(ADDR_W)) u_bank1 (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (bus.wr_en && wr_bank),
    .wr_addr (bus.wr_addr),
    .wr_data (bus.wr_data),
    .rd_en   (rd_en && !wr_bank),
    .rd_addr (pix_cnt),
    .rd_data (rd_data1)
  );

  assign rd_data = rd_sel ? rd_data1 : rd_data0;
`else
  fmap_buf_ram #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .DEPTH(NPIX), .ADDR_W(ADDR_W)) u_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (bus.wr_en),
    .wr_addr (bus.wr_addr),
    .wr_data (bus.wr_data),
    .rd_en   (rd_en),
    .rd_addr (pix_cnt),
    .rd_data (rd_data)
  );
`endif

endmodule

// File: tb/tb_fmap_stream_tx.sv
// Scoreboard bench for fmap_stream_tx: a GAP=0 instance for the main scenarios
// and a GAP=2 instance for beat spacing. Works with or without FMAP_STREAM_TX_PINGPONG_EN.
module tb_fmap_stream_tx;
  import fmap_pkg::*;

  localparam int NPIX  = FRAME_PIX;
  localparam int AW    = $clog2(NPIX);
  localparam int GAP_B = 2;

  typedef struct packed {
    logic sof;
    pix_t pix;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   ls_cyc = 0;
  int   snap = 0;

  exp_t sb_q[2][$];
  pix_t mem_m[2][2][NPIX];
  logic bank_m[2]      = '{1'b0, 1'b0};
  int   load_cnt[2]    = '{0, 0};
  int   frame_beats[2] = '{0, 0};
  int   first_cyc[2]   = '{0, 0};
  int   last_cyc[2]    = '{0, 0};
  logic done_due[2]    = '{1'b0, 1'b0};
  pix_t last_pix[2]    = '{'0, '0};

  fmap_stream_tx_if bus0 ();
  fmap_stream_tx_if bus2 ();

  assign bus2.wr_en        = bus0.wr_en;
  assign bus2.wr_addr      = bus0.wr_addr;
  assign bus2.wr_data      = bus0.wr_data;
  assign bus2.load_success = bus0.load_success;

  fmap_stream_tx #(.GAP(0)) u_dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0.master)
  );

  fmap_stream_tx #(.GAP(GAP_B)) u_dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2.master)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [$bits(pix_t)-1:0] obs,
                             input logic [$bits(pix_t)-1:0] expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at t=%0t", tag, obs, expv, $time);
    end
  endtask

  function automatic logic wrBank(input int inst);
`ifdef FMAP_STREAM_TX_PINGPONG_EN
    return bank_m[inst];
`else
    return 1'b0;
`endif
  endfunction

  task automatic hostWrite(input int addr, input pix_t v);
    bus0.wr_en   = 1'b1;
    bus0.wr_addr = AW'(addr);
    bus0.wr_data = v;
    @(posedge clk);
    #1;
    bus0.wr_en = 1'b0;
    for (int i = 0; i < 2; i++) mem_m[i][wrBank(i)][addr] = v;
  endtask

  task automatic fillFrame(input int seed);
    pix_t v;
    for (int a = 0; a < NPIX; a++) begin
      for (int c = 0; c < DEF_NUM_CH; c++) v[c] = 32'(a * 16 + c) + 32'(seed << 16);
      hostWrite(a, v);
    end
  endtask

  // Accepted start: pulse it and queue the whole expected frame.
  task automatic applyStimulus(input int inst);
    logic rb;
    if (inst == 0) bus0.start = 1'b1;
    else           bus2.start = 1'b1;
    @(posedge clk);
    #1;
    bus0.start = 1'b0;
    bus2.start = 1'b0;
`ifdef FMAP_STREAM_TX_PINGPONG_EN
    bank_m[inst] = ~bank_m[inst];
    rb = ~bank_m[inst];
`else
    rb = 1'b0;
`endif
    for (int a = 0; a < NPIX; a++) sb_q[inst].push_back('{sof: (a == 0), pix: mem_m[inst][rb][a]});
    frame_beats[inst] = 0;
  endtask

  task automatic pulseStart();
    bus0.start = 1'b1;
    @(posedge clk);
    #1;
    bus0.start = 1'b0;
  endtask

  task automatic waitDone(input int inst, input int budget);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      #1;
      seen = (inst == 0) ? bus0.done : bus2.done;
    end
    checkOutput("done_seen", seen, 1);
    checkOutput("busy_clear", (inst == 0) ? bus0.busy : bus2.busy, 0);
    checkOutput("frame_beats", frame_beats[inst], NPIX);
  endtask

  task automatic beatMonitor(input int inst, input logic valid, input logic sof,
                             input pix_t d, input logic done, input logic load);
    exp_t e;
    if (rst) return;
    if (load) load_cnt[inst]++;
    if (done_due[inst]) begin
      checkOutput("done_after_last", done, 1);
      done_due[inst] = 1'b0;
    end else if (done) begin
      checkOutput("done_spurious", done, 0);
    end
    if (valid) begin
      if (sb_q[inst].size() == 0) begin
        checkOutput("extra_beat", valid, 0);
      end else begin
        e = sb_q[inst].pop_front();
        if (inst == 0) begin
          checkOutput("pix", d, e.pix);
          checkOutput("sof", sof, e.sof);
        end else begin
          checkOutput("pix_gap", d, e.pix);
          checkOutput("sof_gap", sof, e.sof);
          if (frame_beats[1] > 0) checkOutput("beat_period", cyc - last_cyc[1], GAP_B + 1);
        end
        if (frame_beats[inst] == 0) first_cyc[inst] = cyc;
        last_cyc[inst] = cyc;
        frame_beats[inst]++;
        if (sb_q[inst].size() == 0) done_due[inst] = 1'b1;
      end
      last_pix[inst] = d;
    end else begin
      checkOutput("d_out_hold", d, last_pix[inst]);
    end
  endtask

  always @(negedge clk) beatMonitor(0, bus0.out_valid, bus0.sof, bus0.d_out, bus0.done, bus0.load);
  always @(negedge clk) beatMonitor(1, bus2.out_valid, bus2.sof, bus2.d_out, bus2.done, bus2.load);

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst               = 1'b1;
    bus0.wr_en        = 1'b0;
    bus0.wr_addr      = '0;
    bus0.wr_data      = '0;
    bus0.start        = 1'b0;
    bus2.start        = 1'b0;
    bus0.load_success = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_busy", bus0.busy, 0);
    checkOutput("rst_done", bus0.done, 0);
    checkOutput("rst_load", bus0.load, 0);
    checkOutput("rst_valid", bus0.out_valid, 0);
    checkOutput("rst_sof", bus0.sof, 0);
    checkOutput("rst_dout", bus0.d_out, 0);
    checkOutput("rst_valid_gap", bus2.out_valid, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    $display("[TB] frame 1: weight load handshake");
    fillFrame(0);
    applyStimulus(0);
    @(negedge clk);
    checkOutput("busy_set", bus0.busy, 1);
    checkOutput("load_pulse", bus0.load, 1);
    @(negedge clk);
    checkOutput("load_width", bus0.load, 0);
    repeat (5) @(posedge clk);
    #1;
    bus0.load_success = 1'b1;
    ls_cyc = cyc;
    waitDone(0, 2000);
    bus0.load_success = 1'b0;
    checkOutput("load_count_f1", load_cnt[0], 1);
    checkOutput("ls_to_first", first_cyc[0] - ls_cyc, 2);

    $display("[TB] frame 2: weights already loaded");
    fillFrame(1);
    applyStimulus(0);
    @(negedge clk);
    checkOutput("lat_cycle1", bus0.out_valid, 0);
    @(negedge clk);
    checkOutput("lat_cycle2", bus0.out_valid, 1);
    waitDone(0, 2000);
    checkOutput("no_reload", load_cnt[0], 1);
    checkOutput("span_gap0", last_cyc[0] - first_cyc[0], NPIX - 1);

    $display("[TB] frame 3: start pulses while busy");
    fillFrame(2);
    applyStimulus(0);
    repeat (20) @(posedge clk);
    #1;
    pulseStart();
    repeat (50) @(posedge clk);
    #1;
    pulseStart();
    repeat (100) @(posedge clk);
    #1;
    pulseStart();
    waitDone(0, 2000);
    repeat (3) @(negedge clk);
    checkOutput("no_queued_start", bus0.busy, 0);

    $display("[TB] frame 4: reset at beat 100");
    fillFrame(3);
    applyStimulus(0);
    for (int k = 0; k < 2000 && frame_beats[0] < 100; k++) begin
      @(negedge clk);
      #1;
    end
    checkOutput("reach_beat100", frame_beats[0], 100);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("abort_busy", bus0.busy, 0);
    checkOutput("abort_done", bus0.done, 0);
    checkOutput("abort_valid", bus0.out_valid, 0);
    checkOutput("abort_sof", bus0.sof, 0);
    checkOutput("abort_dout", bus0.d_out, 0);
    checkOutput("abort_load", bus0.load, 0);
    for (int i = 0; i < 2; i++) begin
      sb_q[i].delete();
      bank_m[i]      = 1'b0;
      done_due[i]    = 1'b0;
      last_pix[i]    = '0;
      frame_beats[i] = 0;
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    fillFrame(4);
    snap = load_cnt[0];
    applyStimulus(0);
    @(negedge clk);
    checkOutput("reload_pulse", bus0.load, 1);
    repeat (2) @(posedge clk);
    #1;
    bus0.load_success = 1'b1;
    waitDone(0, 2000);
    bus0.load_success = 1'b0;
    checkOutput("reload_count", load_cnt[0] - snap, 1);

    $display("[TB] frame 5/6: write collides with stream read at address 50");
    fillFrame(5);
    applyStimulus(0);
    repeat (50) @(posedge clk);
    #1;
    hostWrite(50, {DEF_NUM_CH{32'hDEAD}});
    waitDone(0, 2000);
    applyStimulus(0);
    waitDone(0, 2000);

    $display("[TB] gap instance frame");
    fillFrame(6);
    bus0.load_success = 1'b1;
    applyStimulus(1);
    waitDone(1, 3000);
    bus0.load_success = 1'b0;
    checkOutput("gap_span", last_cyc[1] - first_cyc[1], (NPIX - 1) * (GAP_B + 1));
    checkOutput("gap_load_count", load_cnt[1], 1);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
